cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//   Parametrised, pipelined carry-lookahead adder/subtractor for the FPU mantissa datapath.
//   Generalises the fixed 25-bit CLA: configurable width, group size and pipeline depth.
//   Adds an add/sub mode, signed-overflow/zero flags, a TAG sideband and valid/ready flow control.
//   Sits between exponent-align and normalise stages; one result per cycle when not stalled.
// PARAMETERS
//   WIDTH   25  operand/result width in bits (>=4)
//   GROUP   4   bits per CLA group; last group takes the remainder when WIDTH%GROUP!=0
//   STAGES  2   register stages (= latency); 1 <= STAGES <= NG, where NG=ceil(WIDTH/GROUP)
//   TAGW    4   width of the TAG sideband carried alongside each operation
// PORTS
//   CLK        in   1      clock, rising edge
//   RST_N      in   1      asynchronous active-low reset
//   FLUSH      in   1      synchronous discard of all in-flight operations
//   IN_VALID   in   1      A/B/CIN/SUB/IN_TAG valid
//   IN_READY   out  1      block accepts an operation this cycle
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B
//   CIN        in   1      carry-in (add mode only)
//   SUB        in   1      0: A+B+CIN; 1: A-B (A+~B+1, CIN ignored)
//   IN_TAG     in   TAGW   sideband, returned unchanged with the result
//   OUT_VALID  out  1      result valid
//   OUT_READY  in   1      downstream accepts result
//   OUT        out  WIDTH  sum/difference, modulo 2^WIDTH
//   COUT       out  1      carry out of MSB (sub: 1 = no borrow)
//   OF         out  1      two's-complement overflow
//   ZERO       out  1      OUT == 0
//   OUT_TAG    out  TAGW   IN_TAG of this result
// BEHAVIOUR
//   - Reset (RST_N=0, async): all stage valid bits 0; OUT_VALID=0; OUT/COUT/OF/ZERO/OUT_TAG=0.
//     IN_READY=1 from the first edge after RST_N rises. Reset mid-stream drops all in-flight ops.
//   - Accept on IN_VALID&IN_READY; deliver on OUT_VALID&OUT_READY. Result appears STAGES cycles
//     after acceptance when unstalled; order strictly preserved; one stage holds at most one op.
//   - Carry chain split into NG groups; stage s (0..STAGES-1) resolves groups
//     [s*ceil(NG/STAGES), (s+1)*ceil(NG/STAGES)), registers partial sum, group carry, high
//     operand bits, SUB and TAG. Intra-group carries are lookahead (G/P), no ripple across bits.
//   - Effective operands: Beff = SUB ? ~B : B; c0 = SUB ? 1 : CIN.
//     OUT = A + Beff + c0 [WIDTH-1:0]; COUT = bit WIDTH of that sum;
//     OF = carry into MSB XOR COUT; ZERO = (OUT==0). All flags computed from the same op.
//   - Stall: stage s advances iff empty or stage s+1 advances; last stage advances iff
//     !OUT_VALID or OUT_READY. IN_READY = stage0 can advance (combinational from OUT_READY).
//   - Full pipeline with OUT_READY=0: IN_READY=0; OUT* held stable until handshake.
//   - Simultaneous accept + deliver when full: both occur, throughput 1/cycle, no bubble.
//   - FLUSH=1: all valid bits cleared at the next edge; IN_READY=0 during the FLUSH cycle
//     (input not accepted); OUT_VALID=0 the cycle after. FLUSH has priority over handshakes.
//   - Data outputs while OUT_VALID=0 are don't-care for checking but must not be X after reset.
// TESTING (WIDTH=25, GROUP=4, STAGES=2, TAGW=4)
//   T1 A=0x1FFFFFF B=0 CIN=1 SUB=0 TAG=3 -> 2 cycles later OUT=0, COUT=1, OF=0, ZERO=1, OUT_TAG=3.
//   T2 A=0x0FFFFFF B=1 CIN=0 SUB=0 -> OUT=0x1000000, COUT=0, OF=1, ZERO=0.
//   T3 A=5 B=7 SUB=1 CIN=1 -> OUT=0x1FFFFFE, COUT=0, OF=0; A=7 B=5 SUB=1 -> OUT=2, COUT=1.
//   T4 6 back-to-back ops, OUT_READY=0 for 4 cycles -> IN_READY falls after 2 accepts (+1 if the
//      output slot is free), no loss/duplication, TAG order 0..5 preserved, full rate after release.
//   T5 3 ops in flight, RST_N pulsed low mid-cycle -> OUT_VALID=0 immediately, no stale result out.
//   T6 2 ops in flight, FLUSH=1 with IN_VALID=1 -> op not accepted, OUT_VALID=0 next cycle,
//      next op accepted after FLUSH returns its result after exactly 2 cycles.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Carry groups are spread evenly over STAGES register stages; the last stage is the output register.
module cla_pipe_adder #(
    parameter int WIDTH  = 25,
    parameter int GROUP  = 4,
    parameter int STAGES = 2,
    parameter int TAGW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             of,
    output logic             zero,
    output logic [TAGW-1:0]  out_tag
);

    localparam int NG   = (WIDTH + GROUP - 1) / GROUP;
    localparam int GPS  = (NG + STAGES - 1) / STAGES;
    localparam int LAST = STAGES - 1;

    // Bits whose carry groups are resolved by stage s.
    function automatic logic [WIDTH-1:0] stage_mask(input int s);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i / (GPS * GROUP) == s) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Stage registers
    logic [STAGES-1:0] vld_reg;
    logic [STAGES-1:0] c_reg;
    logic [WIDTH-1:0]  sum_reg [STAGES];
    logic [WIDTH-1:0]  a_reg   [STAGES];
    logic [WIDTH-1:0]  b_reg   [STAGES];
    logic [TAGW-1:0]   tag_reg [STAGES];
    logic              of_reg;
    logic              zero_reg;
    logic              rdy_en_reg;

    // Per-stage combinational inputs and results
    logic [WIDTH-1:0]  in_a_s   [STAGES];
    logic [WIDTH-1:0]  in_b_s   [STAGES];
    logic [WIDTH-1:0]  in_sum_s [STAGES];
    logic [TAGW-1:0]   in_tag_s [STAGES];
    logic [WIDTH-1:0]  sum_next [STAGES];
    logic [STAGES-1:0] in_c_s;
    logic [STAGES-1:0] in_v_s;
    logic [STAGES-1:0] c_next;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  grp_sum;
    logic              accept;
    logic              of_next;
    logic              zero_next;

    // A stage may advance when it, or any stage downstream of it, has room.
    always_comb begin : p_adv
        logic run;
        run = out_ready;
        adv = '0;
        for (int s = LAST; s >= 0; s--) begin
            run    = run | ~vld_reg[s];
            adv[s] = run;
        end
    end

    assign in_ready = rdy_en_reg & adv[0] & ~flush;
    assign accept   = in_valid & in_ready;

    // Subtraction folds into the adder as A + ~B + 1.
    always_comb begin
        in_c_s      = '0;
        in_v_s      = '0;
        in_a_s[0]   = a;
        in_b_s[0]   = sub ? ~b : b;
        in_sum_s[0] = '0;
        in_tag_s[0] = in_tag;
        in_c_s[0]   = sub | cin;
        in_v_s[0]   = accept;
        for (int s = 1; s < STAGES; s++) begin
            in_a_s[s]   = a_reg[s-1];
            in_b_s[s]   = b_reg[s-1];
            in_sum_s[s] = sum_reg[s-1];
            in_tag_s[s] = tag_reg[s-1];
            in_c_s[s]   = c_reg[s-1];
            in_v_s[s]   = vld_reg[s-1];
        end
    end

    genvar gi;

    // One lookahead group per iteration; each carry is a flat sum of G/P products.
    for (gi = 0; gi < NG; gi++) begin : g_grp
        localparam int LO  = gi * GROUP;
        localparam int LEN = (LO + GROUP > WIDTH) ? (WIDTH - LO) : GROUP;
        localparam int SG  = gi / GPS;

        logic [LEN-1:0] gg;
        logic [LEN-1:0] gp;
        logic [LEN:0]   cc;
        logic           cin_g;
        logic           cout_g;
        logic           pchain;
        logic           term;

        assign gg = in_a_s[SG][LO +: LEN] & in_b_s[SG][LO +: LEN];
        assign gp = in_a_s[SG][LO +: LEN] ^ in_b_s[SG][LO +: LEN];

        if (gi % GPS == 0) begin : g_head
            assign cin_g = in_c_s[SG];
        end else begin : g_link
            assign cin_g = g_grp[gi-1].cout_g;
        end

        always_comb begin
            cc = '0;
            for (int j = 0; j <= LEN; j++) begin
                pchain = cin_g;
                for (int m = 0; m < j; m++) begin
                    pchain = pchain & gp[m];
                end
                cc[j] = pchain;
                for (int k = 0; k < j; k++) begin
                    term = gg[k];
                    for (int m = k + 1; m < j; m++) begin
                        term = term & gp[m];
                    end
                    cc[j] = cc[j] | term;
                end
            end
        end

        assign cout_g               = cc[LEN];
        assign grp_sum[LO +: LEN]   = gp ^ cc[LEN-1:0];
    end

    // Stages left without groups simply pass the carry through.
    for (gi = 0; gi < STAGES; gi++) begin : g_stage_carry
        localparam int FIRST = gi * GPS;
        localparam int LASTG = (((gi + 1) * GPS < NG) ? (gi + 1) * GPS : NG) - 1;
        if (FIRST < NG) begin : g_res
            assign c_next[gi] = g_grp[LASTG].cout_g;
        end else begin : g_pass
            assign c_next[gi] = in_c_s[gi];
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            sum_next[s] = (in_sum_s[s] & ~stage_mask(s)) | (grp_sum & stage_mask(s));
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign of_next   = sum_next[LAST][WIDTH-1] ^ in_a_s[LAST][WIDTH-1]
                     ^ in_b_s[LAST][WIDTH-1] ^ c_next[LAST];
    assign zero_next = ~|sum_next[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg    <= '0;
            c_reg      <= '0;
            of_reg     <= 1'b0;
            zero_reg   <= 1'b0;
            rdy_en_reg <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                sum_reg[s] <= '0;
                a_reg[s]   <= '0;
                b_reg[s]   <= '0;
                tag_reg[s] <= '0;
            end
        end else begin
            rdy_en_reg <= 1'b1;
            for (int s = 0; s < STAGES; s++) begin
                if (flush) begin
                    vld_reg[s] <= 1'b0;
                end else if (adv[s]) begin
                    vld_reg[s] <= in_v_s[s];
                end
                if (adv[s] && in_v_s[s]) begin
                    sum_reg[s] <= sum_next[s];
                    c_reg[s]   <= c_next[s];
                    a_reg[s]   <= in_a_s[s];
                    b_reg[s]   <= in_b_s[s];
                    tag_reg[s] <= in_tag_s[s];
                end
            end
            if (adv[LAST] && in_v_s[LAST]) begin
                of_reg   <= of_next;
                zero_reg <= zero_next;
            end
        end
    end

    assign out_valid = vld_reg[LAST];
    assign out       = sum_reg[LAST];
    assign cout      = c_reg[LAST];
    assign of        = of_reg;
    assign zero      = zero_reg;
    assign out_tag   = tag_reg[LAST];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=25, GROUP=4, STAGES=2, TAGW=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cla_pipe_adder;

    localparam int W = 25;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [T-1:0] in_tag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout;
    logic         of;
    logic         zero;
    logic [T-1:0] out_tag;

    int checks = 0;
    int errors = 0;
    int next_op;
    int rcv;
    int acc_early;
    int stall_late;
    int seen_valid;

    always #5 clk = ~clk;

    cla_pipe_adder #(
        .WIDTH (W),
        .GROUP (4),
        .STAGES(2),
        .TAGW  (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .cout     (cout),
        .of       (of),
        .zero     (zero),
        .out_tag  (out_tag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input logic s, input logic [T-1:0] t);
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = c;
        sub      = s;
        in_tag   = t;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            $display("txn tag=%0d out=%h cout=%b of=%b zero=%b", out_tag, out, cout, of, zero);
        end
    end

    initial begin
        rst_n     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
        #1 rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_cout", cout, 0);
        chk("reset_of", of, 0);
        chk("reset_zero", zero, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_in_ready", in_ready, 0);
        #12 rst_n = 1'b1;
        #1 chk("ready_before_edge", in_ready, 0);

        // T1..T3 streamed back to back
        step(); drive(1'b1, 'h1FFFFFF, 'h0, 1'b1, 1'b0, 3);
        @(negedge clk);
        chk("ready_after_reset", in_ready, 1);
        chk("t1_not_early", out_valid, 0);

        step(); drive(1'b1, 'h0FFFFFF, 'h1, 1'b0, 1'b0, 5);
        @(negedge clk);
        chk("t1_latency", out_valid, 0);

        step(); drive(1'b1, 'h5, 'h7, 1'b1, 1'b1, 6);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_out", out, 'h0);
        chk("t1_cout", cout, 1);
        chk("t1_of", of, 0);
        chk("t1_zero", zero, 1);
        chk("t1_tag", out_tag, 3);

        step(); drive(1'b1, 'h7, 'h5, 1'b0, 1'b1, 7);
        @(negedge clk);
        chk("t2_valid", out_valid, 1);
        chk("t2_out", out, 'h1000000);
        chk("t2_cout", cout, 0);
        chk("t2_of", of, 1);
        chk("t2_zero", zero, 0);
        chk("t2_tag", out_tag, 5);

        step(); drive(1'b1, 'h1000000, 'h1, 1'b0, 1'b1, 10);
        @(negedge clk);
        chk("t3a_out", out, 'h1FFFFFE);
        chk("t3a_cout", cout, 0);
        chk("t3a_of", of, 0);
        chk("t3a_zero", zero, 0);
        chk("t3a_tag", out_tag, 6);

        step(); drive(1'b0, '0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("t3b_out", out, 'h2);
        chk("t3b_cout", cout, 1);
        chk("t3b_of", of, 0);
        chk("t3b_tag", out_tag, 7);

        step();
        @(negedge clk);
        chk("t3c_out", out, 'h0FFFFFF);
        chk("t3c_cout", cout, 1);
        chk("t3c_of", of, 1);
        chk("t3c_tag", out_tag, 10);

        step();
        @(negedge clk);
        chk("drained", out_valid, 0);

        // T4: six ops, output blocked for the first four cycles
        next_op    = 0;
        rcv        = 0;
        acc_early  = 0;
        stall_late = 0;
        for (int c = 0; c < 30 && rcv < 6; c++) begin
            step();
            out_ready = (c >= 4);
            drive(next_op < 6, W'(next_op), 'h10, 1'b0, 1'b0, T'(next_op));
            @(negedge clk);
            if (c == 2) chk("t4_ready_low", in_ready, 0);
            if (c == 3) begin
                chk("t4_hold_valid", out_valid, 1);
                chk("t4_hold_tag", out_tag, 0);
                chk("t4_hold_out", out, 'h10);
            end
            if (in_valid && !in_ready && c >= 4) stall_late++;
            if (in_valid && in_ready) begin
                next_op++;
                if (c < 4) acc_early++;
            end
            if (out_valid && out_ready) begin
                chk("t4_order", out_tag, T'(rcv));
                chk("t4_data", out, rcv + 16);
                rcv++;
            end
        end
        chk("t4_early_accepts", acc_early, 2);
        chk("t4_full_rate", stall_late, 0);
        chk("t4_count", rcv, 6);

        // T5: asynchronous reset with the pipeline full
        step(); out_ready = 1'b0; drive(1'b1, 'h1, 'h2, 1'b0, 1'b0, 8);
        step(); drive(1'b1, 'h3, 'h4, 1'b0, 1'b0, 9);
        step(); drive(1'b1, 'h5, 'h6, 1'b0, 1'b0, 11);
        #1;
        chk("t5_pre_valid", out_valid, 1);
        chk("t5_pre_tag", out_tag, 8);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", out_valid, 0);
        chk("t5_async_ready", in_ready, 0);
        chk("t5_async_out", out, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 0);
        seen_valid = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("t5_no_stale", seen_valid, 0);
        chk("t5_ready_back", in_ready, 1);

        // T6: flush with two ops in flight and a third presented
        step(); drive(1'b1, 'h1, 'h1, 1'b0, 1'b0, 1);
        step(); drive(1'b1, 'h2, 'h2, 1'b0, 1'b0, 2);
        step(); drive(1'b1, 'h55, 'h0, 1'b0, 1'b0, 3); flush = 1'b1;
        @(negedge clk);
        chk("t6_flush_ready", in_ready, 0);
        step(); flush = 1'b0; drive(1'b1, 'h100, 'h23, 1'b0, 1'b0, 4);
        @(negedge clk);
        chk("t6_flushed", out_valid, 0);
        chk("t6_ready_after", in_ready, 1);
        step(); drive(1'b0, '0, '0, 1'b0, 1'b0, 0);
        @(negedge clk);
        chk("t6_latency", out_valid, 0);
        step();
        @(negedge clk);
        chk("t6_valid", out_valid, 1);
        chk("t6_tag", out_tag, 4);
        chk("t6_out", out, 'h123);
        step();
        @(negedge clk);
        chk("t6_no_dropped_op", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
